// File: rtl/issue_hazard_ctrl_pkg.sv
// Shared types and helpers for the decode-to-execute issue controller.
package issue_hazard_ctrl_pkg;

    typedef logic [4:0] RegIdx;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        WAIT_CTRL = 2'd1,
        DRAIN     = 2'd2,
        HALT      = 2'd3
    } IssueState;

    localparam RegIdx REG_ZERO = 5'd0;

    // A source only blocks issue when it is really read, is not x0 and has a pending write.
    function automatic logic src_blocked(input logic use_en, input RegIdx idx, input logic busy);
        return use_en & (idx != REG_ZERO) & busy;
    endfunction

endpackage

// File: rtl/issue_hazard_ctrl_reg_scoreboard.sv
// Per-register pending-write counters with in-flight total and sticky underflow error.
module reg_scoreboard
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_en,
    input  RegIdx            inc_rd,
    input  logic             dec_en,
    input  RegIdx            dec_rd,
    input  RegIdx            rd_a,
    input  RegIdx            rd_b,
    output logic             busy_a,
    output logic             busy_b,
    output logic [CNT_W-1:0] inflight,
    output logic             err
);

    // Entry 0 is held at zero so x0 reads as never busy without special-casing the index.
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             err_q, err_d;
    logic             inc_ok_s, dec_ok_s, dec_bad_s;

    // Qualify increment/decrement requests against the registered counts.
    always_comb begin
        inc_ok_s  = 1'b0;
        dec_ok_s  = 1'b0;
        dec_bad_s = 1'b0;
        if (inc_en && (inc_rd != REG_ZERO) && (cnt_q[inc_rd] != {CNT_W{1'b1}})) begin
            inc_ok_s = 1'b1;
        end else begin
            inc_ok_s = 1'b0;
        end
        if (dec_en && (dec_rd != REG_ZERO)) begin
            dec_ok_s  = (cnt_q[dec_rd] != {CNT_W{1'b0}});
            dec_bad_s = (cnt_q[dec_rd] == {CNT_W{1'b0}});
        end else begin
            dec_ok_s  = 1'b0;
            dec_bad_s = 1'b0;
        end
    end

    // Next counter values; a simultaneous inc and dec on one register cancel out.
    always_comb begin
        cnt_d[0] = {CNT_W{1'b0}};
        for (int i = 1; i < 32; i++) begin
            case ({inc_ok_s && (inc_rd == RegIdx'(i)), dec_ok_s && (dec_rd == RegIdx'(i))})
                2'b10:   cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   cnt_d[i] = cnt_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
        case ({inc_ok_s, dec_ok_s})
            2'b10:   inflight_d = inflight_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   inflight_d = inflight_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: inflight_d = inflight_q;
        endcase
        err_d = err_q | dec_bad_s;
    end

    // Scoreboard state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
            inflight_q <= {CNT_W{1'b0}};
            err_q      <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    assign busy_a   = (cnt_q[rd_a] != {CNT_W{1'b0}});
    assign busy_b   = (cnt_q[rd_b] != {CNT_W{1'b0}});
    assign inflight = inflight_q;
    assign err      = err_q;

endmodule

// File: rtl/issue_hazard_ctrl.sv
// Issue controller: scoreboard hazard gating, control-flow blocking/flush, BREAK drain and halt.
module issue_hazard_ctrl
    import issue_hazard_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3,
    parameter int STALL_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               dec_valid,
    output logic               dec_ready,
    input  logic [4:0]         dec_rs1,
    input  logic [4:0]         dec_rs2,
    input  logic               dec_use_rs1,
    input  logic               dec_use_rs2,
    input  logic [4:0]         dec_rd,
    input  logic               dec_reg_write,
    input  logic               dec_ctrl,
    input  logic               dec_break,
    input  logic               dec_fail,
    output logic               iss_valid,
    input  logic               iss_ready,
    input  logic               wb_valid,
    input  logic [4:0]         wb_rd,
    input  logic               res_valid,
    input  logic               res_redirect,
    output logic               flush,
    output logic               halted,
    output logic               sb_err,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    IssueState          state_q, state_d;
    logic               flush_q, flush_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               busy1_s, busy2_s, sb_err_s;
    logic [CNT_W-1:0]   inflight_s;
    logic               hazard_s, fire_s;

    reg_scoreboard #(
        .CNT_W (CNT_W)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc_en   (fire_s & dec_reg_write),
        .inc_rd   (dec_rd),
        .dec_en   (wb_valid),
        .dec_rd   (wb_rd),
        .rd_a     (dec_rs1),
        .rd_b     (dec_rs2),
        .busy_a   (busy1_s),
        .busy_b   (busy2_s),
        .inflight (inflight_s),
        .err      (sb_err_s)
    );

    // Hazards use registered counts only: a writeback this cycle does not unblock a reader.
    assign hazard_s = src_blocked(dec_use_rs1, dec_rs1, busy1_s)
                    | src_blocked(dec_use_rs2, dec_rs2, busy2_s)
                    | (dec_reg_write & (dec_rd != REG_ZERO) & (inflight_s == MAX_CNT));
    assign iss_valid = dec_valid & (state_q == RUN) & ~hazard_s & ~dec_fail;
    assign dec_ready = iss_valid & iss_ready;
    assign fire_s    = dec_ready;

    // Next-state, flush and stall-counter logic.
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        stall_d = stall_q;
        case (state_q)
            RUN: begin
                if (dec_valid && dec_fail) begin
                    state_d = HALT;
                end else if (fire_s && dec_ctrl) begin
                    state_d = WAIT_CTRL;
                end else if (fire_s && dec_break) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            WAIT_CTRL: begin
                if (res_valid) begin
                    state_d = RUN;
                    flush_d = res_redirect;
                end else begin
                    state_d = WAIT_CTRL;
                end
            end
            DRAIN: begin
                if (inflight_s == {CNT_W{1'b0}}) begin
                    state_d = HALT;
                end else begin
                    state_d = DRAIN;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
        if ((state_q == RUN) && dec_valid && !dec_ready && (stall_q != {STALL_W{1'b1}})) begin
            stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
        end else begin
            stall_d = stall_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            flush_q <= 1'b0;
            stall_q <= {STALL_W{1'b0}};
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            stall_q <= stall_d;
        end
    end

    assign flush     = flush_q;
    assign halted    = (state_q == HALT);
    assign sb_err    = sb_err_s;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Directed plus randomized bench for issue_hazard_ctrl, checked against a behavioural model.
module tb_issue_hazard_ctrl;

    localparam int MAXI    = 4;
    localparam int STALL_W = 32;
    localparam int S_RUN   = 0;
    localparam int S_WAIT  = 1;
    localparam int S_DRAIN = 2;
    localparam int S_HALT  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dec_valid = 1'b0, dec_use_rs1 = 1'b0, dec_use_rs2 = 1'b0, dec_reg_write = 1'b0;
    logic dec_ctrl = 1'b0, dec_break = 1'b0, dec_fail = 1'b0;
    logic [4:0] dec_rs1 = 5'd0, dec_rs2 = 5'd0, dec_rd = 5'd0, wb_rd = 5'd0;
    logic iss_ready = 1'b1, wb_valid = 1'b0, res_valid = 1'b0, res_redirect = 1'b0;
    logic dec_ready, iss_valid, flush, halted, sb_err;
    logic [STALL_W-1:0] stall_cnt;

    always #5 clk = ~clk;

    issue_hazard_ctrl #(.MAX_INFLIGHT(MAXI), .CNT_W(3), .STALL_W(STALL_W)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
        .dec_rd(dec_rd), .dec_reg_write(dec_reg_write), .dec_ctrl(dec_ctrl),
        .dec_break(dec_break), .dec_fail(dec_fail), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .res_valid(res_valid), .res_redirect(res_redirect),
        .flush(flush), .halted(halted), .sb_err(sb_err), .stall_cnt(stall_cnt)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // Reference model: pending-write count per architectural register and a total.
    int     m_cnt [32];
    int     m_infl;
    int     m_st;
    bit     m_flush, m_sberr;
    longint m_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 1'b0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0; dec_reg_write = 1'b0;
        dec_ctrl = 1'b0; dec_break = 1'b0; dec_fail = 1'b0;
        dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
        iss_ready = 1'b1; wb_valid = 1'b0; wb_rd = 5'd0; res_valid = 1'b0; res_redirect = 1'b0;
    endtask

    task automatic dec(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2, input bit u2,
                       input logic [4:0] rd, input bit rw, input bit ctrl, input bit brk,
                       input bit fail);
        dec_valid = 1'b1; dec_rs1 = rs1; dec_use_rs1 = u1; dec_rs2 = rs2; dec_use_rs2 = u2;
        dec_rd = rd; dec_reg_write = rw; dec_ctrl = ctrl; dec_break = brk; dec_fail = fail;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_infl = 0; m_st = S_RUN; m_flush = 1'b0; m_sberr = 1'b0; m_stall = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called just after a falling edge with inputs applied; checks, advances the model, waits.
    task automatic tick();
        bit haz, e_iss, e_rdy;
        int nst;
        #1;
        haz = (dec_use_rs1 && dec_rs1 != 5'd0 && m_cnt[dec_rs1] != 0)
           || (dec_use_rs2 && dec_rs2 != 5'd0 && m_cnt[dec_rs2] != 0)
           || (dec_reg_write && dec_rd != 5'd0 && m_infl == MAXI);
        e_iss = dec_valid && (m_st == S_RUN) && !haz && !dec_fail;
        e_rdy = e_iss && iss_ready;
        check("iss_valid", iss_valid, e_iss);
        check("dec_ready", dec_ready, e_rdy);
        check("flush", flush, m_flush);
        check("halted", halted, m_st == S_HALT);
        check("sb_err", sb_err, m_sberr);
        check("stall_cnt", stall_cnt, m_stall);
        if (m_st == S_RUN && dec_valid && !e_rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
        m_flush = (m_st == S_WAIT) && res_valid && res_redirect;
        nst = m_st;
        if (m_st == S_RUN) begin
            if (dec_valid && dec_fail) nst = S_HALT;
            else if (e_rdy && dec_ctrl) nst = S_WAIT;
            else if (e_rdy && dec_break) nst = S_DRAIN;
        end else if (m_st == S_WAIT) begin
            if (res_valid) nst = S_RUN;
        end else if (m_st == S_DRAIN) begin
            if (m_infl == 0) nst = S_HALT;
        end
        m_st = nst;
        if (wb_valid && wb_rd != 5'd0) begin
            if (m_cnt[wb_rd] == 0) m_sberr = 1'b1;
            else begin
                m_cnt[wb_rd]--;
                m_infl--;
            end
        end
        if (e_rdy && dec_reg_write && dec_rd != 5'd0) begin
            m_cnt[dec_rd]++;
            m_infl++;
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset state, then a writer with x0 sources issues at once.
        do_reset();
        tick();
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("t1_iss_same_cycle", iss_valid, 1'b1);
        tick();

        // Reader of x5 stalls until the cycle after its writeback.
        dec(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        wb(5'd5);
        #1 check("t2_no_wb_bypass", iss_valid, 1'b0);
        tick();
        wb_valid = 1'b0;
        #1 check("t2_issue_after_wb", iss_valid, 1'b1);
        check("t2_stall_cycles", stall_cnt, 32'd3);
        tick();
        idle();
        tick();

        // In-flight limit: a fifth writer waits for one retirement.
        do_reset();
        tick();
        for (int r = 1; r <= 4; r++) begin
            dec(5'd0, 1'b0, 5'd0, 1'b0, 5'(r), 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("t3_fifth_blocked", iss_valid, 1'b0);
        tick();
        wb(5'd1);
        tick();
        wb_valid = 1'b0;
        #1 check("t3_fifth_issues", iss_valid, 1'b1);
        tick();

        // Branch blocks issue until resolved; a redirect pulses flush for one cycle.
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 check("t4_wait_blocks", iss_valid, 1'b0);
            tick();
        end
        res_valid = 1'b1; res_redirect = 1'b1;
        tick();
        res_valid = 1'b0; res_redirect = 1'b0;
        #1 check("t4_flush_pulse", flush, 1'b1);
        tick();
        idle();
        #1 check("t4_flush_cleared", flush, 1'b0);
        tick();

        // BREAK drains two pending writes, then halts.
        do_reset();
        tick();
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        wb(5'd1);
        tick();
        wb(5'd2);
        tick();
        wb_valid = 1'b0;
        #1 check("t5_not_yet_halted", halted, 1'b0);
        tick();
        #1 check("t5_halted", halted, 1'b1);
        tick();

        // Writeback with nothing pending sets a sticky error; x0 is never tracked.
        wb(5'd7);
        tick();
        idle();
        #1 check("t6_sb_err_set", sb_err, 1'b1);
        tick();
        tick();
        do_reset();
        tick();
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        wb(5'd0);
        tick();
        wb_valid = 1'b0;
        dec(5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 check("t6_x0_reader", iss_valid, 1'b1);
        tick();

        // Illegal instruction never issues and halts the core.
        dec(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 check("t7_fail_no_issue", iss_valid, 1'b0);
        tick();
        idle();
        #1 check("t7_fail_halts", halted, 1'b1);
        tick();

        // Randomized traffic; re-enters RUN through reset after halting.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (m_st == S_HALT && $urandom_range(0, 7) == 0) do_reset();
            idle();
            if ($urandom_range(0, 3) != 0) begin
                dec(5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 11) == 0, $urandom_range(0, 149) == 0,
                    $urandom_range(0, 199) == 0);
            end
            iss_ready = ($urandom_range(0, 3) != 0);
            if (m_infl > 0 && $urandom_range(0, 1) == 1) begin
                int start;
                bit found;
                start = $urandom_range(1, 31);
                found = 1'b0;
                for (int k = 0; k < 31; k++) begin
                    int r;
                    r = ((start - 1 + k) % 31) + 1;
                    if (!found && m_cnt[r] > 0) begin
                        wb(5'(r));
                        found = 1'b1;
                    end
                end
            end else if ($urandom_range(0, 59) == 0) begin
                wb(5'($urandom_range(0, 31)));
            end
            res_valid    = ($urandom_range(0, 2) == 0);
            res_redirect = ($urandom_range(0, 1) == 1);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
